// File: rtl/quantum_gate_engine.sv
// Quantum gate engine: holds a 2^NQ complex state vector and applies
// single-qubit H/X/Z and two-qubit CNOT gates one amplitude pair per cycle.
module quantum_gate_engine #(
  parameter int NQ = 3,
  parameter int W = 16,
  parameter int FRAC = 8,
  parameter logic [W-1:0] INV_SQRT2 = 16'h00B5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [2:0]    instr_tgt,
  input  logic [2:0]    instr_ctl,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [NQ-1:0] rd_addr,
  output logic [W-1:0]  rd_re,
  output logic [W-1:0]  rd_im
);

  localparam int NAMP = 1 << NQ;
  localparam logic [3:0] NQ4 = 4'(NQ);
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] K = {{(W+1){INV_SQRT2[W-1]}}, INV_SQRT2};
  localparam logic signed [2*W:0] LIMHI = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] LIMLO = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  localparam logic [2:0] OP_INIT = 3'd0;
  localparam logic [2:0] OP_H    = 3'd1;
  localparam logic [2:0] OP_X    = 3'd2;
  localparam logic [2:0] OP_Z    = 3'd3;
  localparam logic [2:0] OP_CNOT = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [NQ-2:0] r_cnt;
  logic [2:0]    r_op;
  logic [2:0]    r_tgt;
  logic [2:0]    r_ctl;
  logic [W-1:0]  r_re [NAMP];
  logic [W-1:0]  r_im [NAMP];

  logic          w_accept;
  logic          w_legal;
  logic [NQ-1:0] w_cntExt;
  logic [NQ-1:0] w_tgtBit;
  logic [NQ-1:0] w_mask;
  logic [NQ-1:0] w_i0;
  logic [NQ-1:0] w_i1;
  logic          w_ctlBit;
  logic [W-1:0]  w_a0Re, w_a0Im, w_a1Re, w_a1Im;
  logic [W:0]    w_sumRe, w_sumIm, w_difRe, w_difIm;
  logic [W-1:0]  w_n0Re, w_n0Im, w_n1Re, w_n1Im;

  // Scale a W+1 bit sum/difference by 1/sqrt(2), floor the shift, saturate to W bits
  function automatic logic [W-1:0] hScale(input logic [W:0] s);
    logic signed [2*W:0] p;
    logic signed [2*W:0] q;
    p = $signed({{W{s[W]}}, s}) * K;
    q = p >>> FRAC;
    if (q > LIMHI) return MAXW;
    else if (q < LIMLO) return MINW;
    else return q[W-1:0];
  endfunction

  // Negate with saturation so the most negative value maps to the most positive
  function automatic logic [W-1:0] satNeg(input logic [W-1:0] a);
    if (a == MINW) return MAXW;
    else return -a;
  endfunction

  assign instr_ready = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign rd_re       = r_re[rd_addr];
  assign rd_im       = r_im[rd_addr];

  assign w_accept = instr_valid & r_ready;

  // Legality is judged on the live instruction fields at the accept cycle
  always_comb begin
    w_legal = 1'b1;
    if (instr_op > OP_CNOT) w_legal = 1'b0;
    if ({1'b0, instr_tgt} >= NQ4) w_legal = 1'b0;
    if (instr_op == OP_CNOT) begin
      if ({1'b0, instr_ctl} >= NQ4) w_legal = 1'b0;
      if (instr_ctl == instr_tgt) w_legal = 1'b0;
    end
  end

  // Pair index: counter with a zero inserted at the target bit position
  assign w_cntExt = {1'b0, r_cnt};
  assign w_tgtBit = NQ'(1) << r_tgt;
  assign w_mask   = w_tgtBit - NQ'(1);
  assign w_i0     = ((w_cntExt & ~w_mask) << 1) | (w_cntExt & w_mask);
  assign w_i1     = w_i0 | w_tgtBit;
  assign w_ctlBit = |(w_i0 & (NQ'(1) << r_ctl));

  assign w_a0Re = r_re[w_i0];
  assign w_a0Im = r_im[w_i0];
  assign w_a1Re = r_re[w_i1];
  assign w_a1Im = r_im[w_i1];

  assign w_sumRe = {w_a0Re[W-1], w_a0Re} + {w_a1Re[W-1], w_a1Re};
  assign w_sumIm = {w_a0Im[W-1], w_a0Im} + {w_a1Im[W-1], w_a1Im};
  assign w_difRe = {w_a0Re[W-1], w_a0Re} - {w_a1Re[W-1], w_a1Re};
  assign w_difIm = {w_a0Im[W-1], w_a0Im} - {w_a1Im[W-1], w_a1Im};

  // Gate datapath: new values for the current amplitude pair
  always_comb begin
    w_n0Re = w_a0Re;
    w_n0Im = w_a0Im;
    w_n1Re = w_a1Re;
    w_n1Im = w_a1Im;
    case (r_op)
      OP_H: begin
        w_n0Re = hScale(w_sumRe);
        w_n0Im = hScale(w_sumIm);
        w_n1Re = hScale(w_difRe);
        w_n1Im = hScale(w_difIm);
      end
      OP_X: begin
        w_n0Re = w_a1Re;
        w_n0Im = w_a1Im;
        w_n1Re = w_a0Re;
        w_n1Im = w_a0Im;
      end
      OP_Z: begin
        w_n1Re = satNeg(w_a1Re);
        w_n1Im = satNeg(w_a1Im);
      end
      OP_CNOT: begin
        if (w_ctlBit) begin
          w_n0Re = w_a1Re;
          w_n0Im = w_a1Im;
          w_n1Re = w_a0Re;
          w_n1Im = w_a0Im;
        end
      end
      default: ;
    endcase
  end

  // Control FSM and state-vector storage; reset returns to |0...0>
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_tgt   <= '0;
      r_ctl   <= '0;
      for (int i = 0; i < NAMP; i++) begin
        r_re[i] <= (i == 0) ? ONE : '0;
        r_im[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (w_accept) begin
            r_op    <= instr_op;
            r_tgt   <= instr_tgt;
            r_ctl   <= instr_ctl;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            if (!w_legal) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (instr_op == OP_INIT) begin
              for (int i = 0; i < NAMP; i++) begin
                r_re[i] <= (i == 0) ? ONE : '0;
                r_im[i] <= '0;
              end
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_re[w_i0] <= w_n0Re;
          r_im[w_i0] <= w_n0Im;
          r_re[w_i1] <= w_n1Re;
          r_im[w_i1] <= w_n1Im;
          if (&r_cnt) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
